// File: rtl/p405s_execrctrupd_if.sv
// rtl/p405s_execrctrupd_if.sv - request/result bundle for the CR/CTR update block
interface p405s_execrctrupd_if;
  logic        exeHold;
  logic        exeFlush;
  logic        exeBcValid;
  logic [0:3]  exeBOL2;
  logic        exeMtCtrValid;
  logic [0:31] exeMtCtrData;
  logic        exeCrFldValid;
  logic [0:2]  exeCrFldSel;
  logic [0:3]  exeCrFldData;
  logic        wbCrWrValid;
  logic [0:7]  wbCrFldMask;
  logic [0:31] wbCrData;
  logic [0:31] crL2;
  logic [0:31] ctrL2;
  logic        exeCtrEq0;

  modport master (
    output exeHold, exeFlush, exeBcValid, exeBOL2, exeMtCtrValid, exeMtCtrData,
           exeCrFldValid, exeCrFldSel, exeCrFldData, wbCrWrValid, wbCrFldMask, wbCrData,
    input  crL2, ctrL2, exeCtrEq0
  );

  modport slave (
    input  exeHold, exeFlush, exeBcValid, exeBOL2, exeMtCtrValid, exeMtCtrData,
           exeCrFldValid, exeCrFldSel, exeCrFldData, wbCrWrValid, wbCrFldMask, wbCrData,
    output crL2, ctrL2, exeCtrEq0
  );
endinterface

// File: rtl/p405s_execrctrupd.sv
// rtl/p405s_execrctrupd.sv - architected CR and CTR owner with registered CTR==1 flag
module p405s_execrctrupd (
  input logic                     CB,
  input logic                     coreReset_Neg,
  p405s_execrctrupd_if.slave      crCtrIf
);

  logic        exeEn;
  logic        ctrDec;
  logic [0:31] ctrNext;
  logic [0:31] crNext;
  logic        unusedBo;

  // Only BO[2] (decrement-disable) matters here; the other bits belong to the evaluator.
  assign unusedBo = ^{crCtrIf.exeBOL2[0:1], crCtrIf.exeBOL2[3]};

  assign exeEn  = ~crCtrIf.exeHold & ~crCtrIf.exeFlush;
  assign ctrDec = crCtrIf.exeBcValid & exeEn & ~crCtrIf.exeBOL2[2];

  // CTR next value: mtctr beats a same-cycle decrement; decrement wraps modulo 2^32.
  always_comb begin
    ctrNext = crCtrIf.ctrL2;
    if (crCtrIf.exeMtCtrValid & exeEn) begin
      ctrNext = crCtrIf.exeMtCtrData;
    end else if (ctrDec) begin
      ctrNext = crCtrIf.ctrL2 - 32'd1;
    end
  end

  // CR next value per 4-bit field: the younger EXE result wins over the WB write.
  always_comb begin
    crNext = crCtrIf.crL2;
    for (int i = 0; i < 8; i++) begin
      if (crCtrIf.exeCrFldValid & exeEn & (crCtrIf.exeCrFldSel == 3'(i))) begin
        crNext[4*i +: 4] = crCtrIf.exeCrFldData;
      end else if (crCtrIf.wbCrWrValid & crCtrIf.wbCrFldMask[i]) begin
        crNext[4*i +: 4] = crCtrIf.wbCrData[4*i +: 4];
      end
    end
  end

  // Commit CR, CTR and the look-ahead zero flag together so the evaluator sees flop outputs.
  always_ff @(posedge CB or negedge coreReset_Neg) begin
    if (!coreReset_Neg) begin
      crCtrIf.crL2      <= '0;
      crCtrIf.ctrL2     <= '0;
      crCtrIf.exeCtrEq0 <= 1'b0;
    end else begin
      crCtrIf.crL2      <= crNext;
      crCtrIf.ctrL2     <= ctrNext;
      crCtrIf.exeCtrEq0 <= (ctrNext == 32'h0000_0001);
    end
  end

endmodule

// File: tb/tb_p405s_execrctrupd.sv
// tb/tb_p405s_execrctrupd.sv - directed self-checking bench for p405s_execrctrupd
module tb_p405s_execrctrupd;
  logic CB;
  logic coreReset_Neg;
  int   testsRun;
  int   testsFailed;

  p405s_execrctrupd_if ifc ();

  p405s_execrctrupd dut (
    .CB            (CB),
    .coreReset_Neg (coreReset_Neg),
    .crCtrIf       (ifc)
  );

  initial CB = 1'b0;
  always #5 CB = ~CB;

  task automatic clearInputs();
    ifc.exeHold       = 1'b0;
    ifc.exeFlush      = 1'b0;
    ifc.exeBcValid    = 1'b0;
    ifc.exeBOL2       = 4'b0000;
    ifc.exeMtCtrValid = 1'b0;
    ifc.exeMtCtrData  = 32'h0;
    ifc.exeCrFldValid = 1'b0;
    ifc.exeCrFldSel   = 3'd0;
    ifc.exeCrFldData  = 4'h0;
    ifc.wbCrWrValid   = 1'b0;
    ifc.wbCrFldMask   = 8'h00;
    ifc.wbCrData      = 32'h0;
  endtask

  task automatic tick();
    @(posedge CB);
    #1;
  endtask

  task automatic doMtCtr(input logic [31:0] val);
    ifc.exeMtCtrValid = 1'b1;
    ifc.exeMtCtrData  = val;
    tick();
    clearInputs();
  endtask

  task automatic doBc(input logic [3:0] bo);
    ifc.exeBcValid = 1'b1;
    ifc.exeBOL2    = bo;
    tick();
    clearInputs();
  endtask

  task automatic checkCtr(input string name, input logic [31:0] expCtr, input logic expEq0);
    testsRun++;
    if (ifc.ctrL2 !== expCtr) begin
      testsFailed++;
      $display("FAIL %s ctrL2 got %h expected %h", name, ifc.ctrL2, expCtr);
    end
    testsRun++;
    if (ifc.exeCtrEq0 !== expEq0) begin
      testsFailed++;
      $display("FAIL %s exeCtrEq0 got %b expected %b", name, ifc.exeCtrEq0, expEq0);
    end
  endtask

  task automatic checkCr(input string name, input logic [31:0] expCr);
    testsRun++;
    if (ifc.crL2 !== expCr) begin
      testsFailed++;
      $display("FAIL %s crL2 got %h expected %h", name, ifc.crL2, expCr);
    end
  endtask

  task automatic test_reset();
    doMtCtr(32'h1);
    ifc.wbCrWrValid = 1'b1;
    ifc.wbCrFldMask = 8'hFF;
    ifc.wbCrData    = 32'h1234_5678;
    tick();
    clearInputs();
    checkCtr("preReset", 32'h1, 1'b1);
    checkCr("preReset", 32'h1234_5678);
    #2;
    coreReset_Neg = 1'b0;
    #1;
    checkCtr("asyncReset", 32'h0, 1'b0);
    checkCr("asyncReset", 32'h0);
    tick();
    #2;
    coreReset_Neg = 1'b1;
    tick();
    checkCtr("afterRelease", 32'h0, 1'b0);
  endtask

  task automatic test_load_dec();
    doMtCtr(32'h3);
    checkCtr("mtctr3", 32'h3, 1'b0);
    doBc(4'b0000);
    checkCtr("dec1", 32'h2, 1'b0);
    doBc(4'b0000);
    checkCtr("dec2", 32'h1, 1'b1);
    doBc(4'b0000);
    checkCtr("dec3", 32'h0, 1'b0);
  endtask

  task automatic test_wrap();
    doBc(4'b0000);
    checkCtr("wrap", 32'hFFFF_FFFF, 1'b0);
    doMtCtr(32'h1);
    checkCtr("mtctr1", 32'h1, 1'b1);
  endtask

  task automatic test_suppress();
    doMtCtr(32'h9);
    doBc(4'b0010);
    checkCtr("boNoDec", 32'h9, 1'b0);
    ifc.exeFlush = 1'b1;
    doBc(4'b0000);
    checkCtr("flushBc", 32'h9, 1'b0);
    doMtCtr(32'h5);
    ifc.exeBcValid = 1'b1;
    ifc.exeBOL2    = 4'b0000;
    ifc.exeHold    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkCtr("holdBc", 32'h5, 1'b0);
    end
    ifc.exeHold = 1'b0;
    tick();
    clearInputs();
    checkCtr("holdRelease", 32'h4, 1'b0);
    tick();
    checkCtr("holdOnce", 32'h4, 1'b0);
  endtask

  task automatic test_conflict();
    doMtCtr(32'h7);
    ifc.exeMtCtrValid = 1'b1;
    ifc.exeMtCtrData  = 32'h10;
    ifc.exeBcValid    = 1'b1;
    ifc.exeBOL2       = 4'b0000;
    tick();
    clearInputs();
    checkCtr("conflict", 32'h10, 1'b0);
  endtask

  task automatic test_cr_merge();
    ifc.wbCrWrValid   = 1'b1;
    ifc.wbCrFldMask   = 8'hFF;
    ifc.wbCrData      = 32'hFFFF_FFFF;
    ifc.exeCrFldValid = 1'b1;
    ifc.exeCrFldSel   = 3'd2;
    ifc.exeCrFldData  = 4'b0100;
    tick();
    clearInputs();
    checkCr("crMerge", 32'hFF4F_FFFF);
    ifc.wbCrWrValid = 1'b1;
    ifc.wbCrFldMask = 8'hFF;
    ifc.wbCrData    = 32'h0;
    tick();
    clearInputs();
    checkCr("crClear", 32'h0);
    ifc.wbCrWrValid = 1'b1;
    ifc.wbCrFldMask = 8'b1000_0001;
    ifc.wbCrData    = 32'hA555_555B;
    tick();
    clearInputs();
    checkCr("partialMask", 32'hA000_000B);
  endtask

  task automatic test_flush_hold_wb();
    ifc.exeHold       = 1'b1;
    ifc.exeFlush      = 1'b1;
    ifc.exeCrFldValid = 1'b1;
    ifc.exeCrFldSel   = 3'd7;
    ifc.exeCrFldData  = 4'h3;
    ifc.wbCrWrValid   = 1'b1;
    ifc.wbCrFldMask   = 8'b0100_0000;
    ifc.wbCrData      = 32'h0600_0000;
    tick();
    clearInputs();
    checkCr("flushHoldWb", 32'hA600_000B);
  endtask

  task automatic test_back_to_back();
    ifc.exeCrFldValid = 1'b1;
    ifc.exeCrFldSel   = 3'd3;
    ifc.exeCrFldData  = 4'h9;
    ifc.exeMtCtrValid = 1'b1;
    ifc.exeMtCtrData  = 32'h2;
    tick();
    clearInputs();
    checkCr("b2bCr", 32'hA609_000B);
    checkCtr("b2bMt", 32'h2, 1'b0);
    doBc(4'b0000);
    checkCtr("b2bDec1", 32'h1, 1'b1);
    doBc(4'b0000);
    checkCtr("b2bDec2", 32'h0, 1'b0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    clearInputs();
    coreReset_Neg = 1'b0;
    #12;
    coreReset_Neg = 1'b1;
    tick();
    test_reset();
    test_load_dec();
    test_wrap();
    test_suppress();
    test_conflict();
    test_cr_merge();
    test_flush_hold_wb();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
